// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: shared formats, error codes, opcodes and the encoded-word record
package instruction_encoder_pkg;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_format_t;
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } enc_err_t;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    enc_err_t    code;
  } enc_word_t;
endpackage

// File: rtl/instruction_encoder_imm_scatter.sv
// instruction_encoder_imm_scatter: places imm into format bit positions and flags range/alignment/format errors (fmt,imm -> imm_bits,err_code)
module instruction_encoder_imm_scatter
  import instruction_encoder_pkg::*;
(
  input  inst_format_t fmt,
  input  logic [31:0]  imm,
  output logic [31:0]  imm_bits,
  output enc_err_t     err_code
);
  logic rng_i, rng_b, rng_j, rng_u, odd;
  assign rng_i = !(&imm[31:11] || ~|imm[31:11]);
  assign rng_b = !(&imm[31:12] || ~|imm[31:12]);
  assign rng_j = !(&imm[31:20] || ~|imm[31:20]);
  assign rng_u = |imm[11:0];
  assign odd   = imm[0];
  always_comb begin
    imm_bits = '0;
    err_code = ERR_NONE;
    case (fmt)
      FMT_R: ;
      FMT_I: begin
        imm_bits = {imm[11:0], 20'b0};
        err_code = rng_i ? ERR_RANGE : ERR_NONE;
      end
      FMT_S: begin
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        err_code = rng_i ? ERR_RANGE : ERR_NONE;
      end
      FMT_B: begin
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        err_code = odd ? ERR_ALIGN : rng_b ? ERR_RANGE : ERR_NONE;
      end
      FMT_U: begin
        imm_bits = {imm[31:12], 12'b0};
        err_code = rng_u ? ERR_RANGE : ERR_NONE;
      end
      FMT_J: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        err_code = odd ? ERR_ALIGN : rng_j ? ERR_RANGE : ERR_NONE;
      end
      default: err_code = ERR_FMT;
    endcase
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: streaming RV32 encoder with 2-entry skid buffer and saturating counters (in_* request -> out_* word, enc_count/err_count)
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  inst_format_t     in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  enc_word_t   enc_w, out_w, skid_w;
  enc_err_t    code;
  logic [31:0] imm_bits, fields;
  logic        skid_valid, accept, drain, to_skid, skid_next;
  logic        has_rd, has_rs1, has_rs2, has_f7;
  instruction_encoder_imm_scatter u_scatter (
    .fmt      (in_fmt),
    .imm      (in_imm),
    .imm_bits (imm_bits),
    .err_code (code)
  );
  assign has_rd  = in_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
  assign has_rs1 = in_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign has_rs2 = in_fmt inside {FMT_R, FMT_S, FMT_B};
  assign has_f7  = in_fmt == FMT_R;
  assign fields = {has_f7 ? in_funct7 : 7'b0, has_rs2 ? in_rs2 : 5'b0, has_rs1 ? in_rs1 : 5'b0,
                   has_rs1 ? in_funct3 : 3'b0, has_rd ? in_rd : 5'b0, in_opcode};
  always_comb begin
    enc_w.instr = code == ERR_FMT ? 32'b0 : fields | imm_bits;
    enc_w.err   = code != ERR_NONE;
    enc_w.code  = code;
  end
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign to_skid   = accept && out_valid && !drain;
  assign skid_next = to_skid || (skid_valid && !drain);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_w      <= '0;
      skid_w     <= '0;
      enc_count  <= '0;
      err_count  <= '0;
    end else begin
      if (drain && skid_valid) out_w <= skid_w;
      else if (accept && (!out_valid || drain)) out_w <= enc_w;
      if (to_skid) skid_w <= enc_w;
      out_valid  <= skid_valid || (out_valid && !drain) || accept;
      skid_valid <= skid_next;
      in_ready   <= !skid_next;
      if (drain && !(&enc_count)) enc_count <= enc_count + 1'b1;
      if (drain && out_w.err && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
  assign out_instr    = out_w.instr;
  assign out_err      = out_w.err;
  assign out_err_code = out_w.code;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and random checks of instruction_encoder against a queue-based reference model
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;
  localparam int CW = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_err;
  inst_format_t in_fmt = FMT_R;
  logic [6:0] in_opcode = '0, in_funct7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_imm = '0, out_instr;
  logic [1:0] out_err_code;
  logic [CW-1:0] enc_count, err_count;
  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, n_enc = 0, n_err = 0;
  always #5 clk = ~clk;
  instruction_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .out_err_code(out_err_code), .enc_count(enc_count), .err_count(err_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  function automatic int sat(input int n);
    return n > 15 ? 15 : n;
  endfunction
  function automatic exp_t ref_enc(input inst_format_t f, input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
    exp_t e;
    int s;
    logic [31:0] w;
    bit rng, al, bad;
    s = $signed(imm);
    rng = 0; al = 0; bad = 0;
    w = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (f)
      FMT_R: w = w | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      FMT_I: begin
        w = w | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
        rng = s < -2048 || s > 2047;
      end
      FMT_S: begin
        w = w | ((imm & 31) << 7) | (32'(rs2) << 20) | (((imm >> 5) & 127) << 25);
        rng = s < -2048 || s > 2047;
      end
      FMT_B: begin
        w = w | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (32'(rs2) << 20)
              | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
        rng = s < -4096 || s > 4095;
        al = imm % 2 != 0;
      end
      FMT_U: begin
        w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFFF000);
        rng = imm % 4096 != 0;
      end
      FMT_J: begin
        w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
              | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
        rng = s < -(1 << 20) || s > (1 << 20) - 1;
        al = imm % 2 != 0;
      end
      default: bad = 1;
    endcase
    e.instr = bad ? 32'h0 : w;
    e.code = bad ? 2'd3 : al ? 2'd2 : rng ? 2'd1 : 2'd0;
    e.err = e.code != 2'd0;
    return e;
  endfunction
  task automatic cyc();
    bit acc, dr;
    exp_t e, h;
    e = ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_err", 32'(out_err), 32'(q[0].err));
      chk("out_err_code", 32'(out_err_code), 32'(q[0].code));
    end
    acc = in_valid && q.size() < 2;
    dr = out_ready && q.size() > 0;
    @(posedge clk); #1;
    if (dr) begin
      h = q.pop_front();
      n_enc++;
      if (h.err) n_err++;
    end
    if (acc) q.push_back(e);
    chk("enc_count", 32'(enc_count), 32'(sat(n_enc)));
    chk("err_count", 32'(err_count), 32'(sat(n_err)));
  endtask
  task automatic put(input inst_format_t f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1;
  endtask
  task automatic put_rand();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      2: imm = $urandom & 32'hFFFFF000;
      default: imm = 32'($urandom_range(0, 1 << 21)) - 32'(1 << 20);
    endcase
    put(inst_format_t'(3'($urandom_range(0, 7))), 7'($urandom), 5'($urandom), 5'($urandom),
        5'($urandom), 3'($urandom), 7'($urandom), imm);
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    n_enc = 0;
    n_err = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_err_code", 32'(out_err_code), 0);
    chk("rst_enc_count", 32'(enc_count), 0);
    chk("rst_err_count", 32'(err_count), 0);
  endtask
  initial begin
    bit will_acc;
    @(posedge clk); #1;
    do_reset();
    out_ready = 1;
    put(FMT_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    cyc();
    in_valid = 0;
    chk("i_valid_next", 32'(out_valid), 1);
    chk("i_word", out_instr, 32'hFFF00093);
    chk("i_err", 32'(out_err), 0);
    cyc();
    put(FMT_B, OPC_BRANCH, 0, 1, 2, 0, 0, 8);
    cyc();
    chk("b_word", out_instr, 32'h00208463);
    put(FMT_B, OPC_BRANCH, 0, 1, 2, 0, 0, 3);
    cyc();
    chk("b_align_err", 32'(out_err), 1);
    chk("b_align_code", 32'(out_err_code), 32'(ERR_ALIGN));
    put(FMT_B, OPC_BRANCH, 0, 1, 2, 0, 0, 4096);
    cyc();
    chk("b_range_code", 32'(out_err_code), 32'(ERR_RANGE));
    put(FMT_J, OPC_JAL, 1, 0, 0, 0, 0, 32'h800);
    cyc();
    chk("j_word", out_instr, 32'h001000EF);
    put(FMT_U, OPC_LUI, 5, 0, 0, 0, 0, 32'h12345000);
    cyc();
    chk("u_word", out_instr, 32'h123452B7);
    put(FMT_U, OPC_LUI, 5, 0, 0, 0, 0, 32'h12345001);
    cyc();
    chk("u_range_code", 32'(out_err_code), 32'(ERR_RANGE));
    put(inst_format_t'(3'd7), OPC_LUI, 5, 1, 2, 3, 4, 32'h0);
    cyc();
    in_valid = 0;
    chk("fmt_code", 32'(out_err_code), 32'(ERR_FMT));
    chk("fmt_word", out_instr, 0);
    cyc();
    do_reset();
    out_ready = 0;
    put(FMT_I, OPC_OP_IMM, 3, 4, 0, 2, 0, 32'd100);
    cyc();
    put(FMT_S, OPC_STORE, 0, 6, 7, 2, 0, 32'hFFFFFFF0);
    cyc();
    put(FMT_R, 7'b0110011, 8, 9, 10, 0, 7'b0100000, 0);
    cyc();
    chk("stall_in_ready", 32'(in_ready), 0);
    cyc();
    cyc();
    out_ready = 1;
    for (int i = 0; i < 10 && in_valid; i++) begin
      will_acc = in_valid && q.size() < 2;
      cyc();
      if (will_acc) in_valid = 0;
    end
    chk("third_accepted", 32'(in_valid), 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
    chk("stall_enc_count", 32'(enc_count), 3);
    chk("stall_drained", 32'(out_valid), 0);
    out_ready = 0;
    put(FMT_J, OPC_JAL, 2, 0, 0, 0, 0, 32'h1000);
    cyc();
    cyc();
    do_reset();
    out_ready = 1;
    put(FMT_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    cyc();
    in_valid = 0;
    chk("post_rst_word", out_instr, 32'hFFF00093);
    cyc();
    for (int i = 0; i < 24; i++) begin
      put_rand();
      cyc();
    end
    in_valid = 0;
    cyc();
    chk("enc_sat", 32'(enc_count), 15);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) put_rand();
      else in_valid = 0;
      out_ready = $urandom_range(0, 2) != 0;
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
    chk("final_empty", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Streaming RV32 instruction encoder: packs a format tag, register/function fields and a 32-bit signed immediate into a 32-bit instruction word.
- It is the inverse of the decode-side immediate extraction: the immediate is scattered into the format-specific bit positions.
- Used by the trap/trampoline generator and self-test sequencer to synthesise instructions at run time.
- Valid/ready on both sides, two-entry skid buffering, immediate range/alignment checking and usage counters.

Parameters:
CNT_W, 16, width of the enc_count and err_count saturating counters.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request
in_fmt  input  inst_format_t  R/I/S/B/U/J format tag
in_opcode  input  7  placed at [6:0]
in_rd  input  5  placed at [11:7] for R/I/U/J
in_rs1  input  5  placed at [19:15] for R/I/S/B
in_rs2  input  5  placed at [24:20] for R/S/B
in_funct3  input  3  placed at [14:12] for R/I/S/B
in_funct7  input  7  placed at [31:25] for R only
in_imm  input  32  signed byte-offset immediate; ignored for R
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts the word
out_instr  output  32  encoded instruction
out_err  output  1  immediate or format error on this word
out_err_code  output  2  0=NONE, 1=RANGE, 2=ALIGN, 3=FMT
enc_count  output  CNT_W  output handshakes completed
err_count  output  CNT_W  output handshakes with out_err=1

Behaviour:
- Reset values: out_valid=0, in_ready=1, out_instr=0, out_err=0, out_err_code=0, counters=0. Reset mid-stream discards both buffered entries.
- Latency: a word accepted in cycle N (in_valid&&in_ready) appears on out_valid in cycle N+1 if the output register is empty or draining.
- Storage is a main output register plus one skid register. in_ready is registered and equals !skid_valid.
- Accept while the output is stalled (out_valid && !out_ready): the word goes to the skid register.
- Output handshake while skid is occupied: the skid word moves to the output register in the same edge.
- Simultaneous accept and drain with skid empty: the new word loads the output register directly.
- Strict FIFO order. No word is dropped or duplicated.
- out_* fields stay stable while out_valid && !out_ready.
- Immediate placement:
  - I: imm[11:0] to [31:20].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - U: imm[31:12] to [31:12].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
- Range checks:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal.
  - J: imm[31:20] all equal.
  - U: imm[11:0]==0 (a violation reports RANGE).
- Alignment checks: B and J require imm[0]==0.
- An unknown format tag reports FMT.
- Error priority: FMT > ALIGN > RANGE.
- On error the word is still emitted with truncated fields and out_err=1. On FMT, out_instr=0.
- Counters update only on output handshake and saturate at 2^CNT_W-1 without wrapping. err_count increments only when out_err=1.

Decomposition:
- Package types holds inst_format_t (add R_TYPE if absent), enc_err_t (NONE/RANGE/ALIGN/FMT), and opcode constants (OP_IMM, LUI, JAL, BRANCH, STORE).
- Sub-module imm_scatter is combinational. It takes fmt and imm and returns placed immediate bits and err_code.
- The top module contains field muxing, the skid buffer and the counters.

Test Plan:
- I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, err=0, out_valid one cycle after accept.
- B, opcode 1100011, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463. Then imm=3 -> err=1, code ALIGN. Then imm=4096 -> code RANGE.
- J, opcode 1101111, rd=1, imm=0x800 -> 0x001000EF. U, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7. U with imm=0x12345001 -> RANGE.
- Hold out_ready=0 and offer 3 back-to-back words -> 2 accepted, in_ready=0 on the third. Release -> words emerge in order with stable fields during the stall, and enc_count=3 after the third handshake.
- Assert rst for one cycle with both entries full -> next cycle out_valid=0, in_ready=1, counters=0, and the following request encodes correctly.
- Force enc_count to max with CNT_W=4 and complete 20 handshakes -> enc_count holds at 15.
